// File: rtl/sblk_psum_drain.sv
// Partial-sum drain: deskews the column-skewed psum bus, requantizes every lane and streams packed words out of a FIFO.
// Optional feature macro: PSUM_DRAIN_SAT_EN (saturate lanes to WID_OUT instead of wrapping).
module sblk_psum_drain #(
    parameter int N_COLUMN   = 4,
    parameter int WID_PSUM   = 32,
    parameter int WID_OUT    = 8,
    parameter int WID_SHIFT  = 5,
    parameter int WID_LEN    = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk_l,
    input  logic                            rst_n,
    input  logic [2*WID_PSUM*N_COLUMN-1:0]  psum_rd_data,
    input  logic                            psum_vld,
    output logic                            psum_rdy,
    input  logic [WID_SHIFT-1:0]            cfg_shift,
    input  logic [WID_LEN-1:0]              cfg_len,
    output logic [2*WID_OUT*N_COLUMN-1:0]   out_data,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic                            drain_done,
    output logic                            ovf_err
);

    localparam int LANES = 2 * N_COLUMN;
    localparam int CW    = 2 * WID_PSUM;
    localparam int OW    = 2 * WID_OUT * N_COLUMN;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OCW   = PW + 1;
    localparam int SW    = OCW + 1;

`ifdef PSUM_DRAIN_SAT_EN
    localparam logic signed [WID_PSUM:0] SAT_HI = {{(WID_PSUM+2-WID_OUT){1'b0}}, {(WID_OUT-1){1'b1}}};
    localparam logic signed [WID_PSUM:0] SAT_LO = {{(WID_PSUM+2-WID_OUT){1'b1}}, {(WID_OUT-1){1'b0}}};
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic [N_COLUMN-2:0]    vld_sr;
    logic [CW*N_COLUMN-1:0] aligned;
    logic [OW-1:0]          q_data_d;
    logic [OW-1:0]          q_data;
    logic                   q_vld;
    logic [OW-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [OCW-1:0]         occ;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   wr_en;
    logic                   ovf_q;
    logic [SW-1:0]          inflight;
    logic [SW-1:0]          used;
    state_t                 state_q, state_d;
    logic [WID_LEN-1:0]     len_q, len_d;
    logic [WID_LEN-1:0]     cnt_q, cnt_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= psum_vld;
            for (int i = 1; i < N_COLUMN - 1; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    // Column ii arrives ii cycles late, so it gets N_COLUMN-1-ii delays to line up with the last column.
    for (genvar ii = 0; ii < N_COLUMN; ii++) begin : g_col
        localparam int D = N_COLUMN - 1 - ii;
        if (D == 0) begin : g_direct
            assign aligned[CW*ii +: CW] = psum_rd_data[CW*ii +: CW];
        end else begin : g_dly
            logic [CW-1:0] dly [D];
            always_ff @(posedge clk_l) begin
                dly[0] <= psum_rd_data[CW*ii +: CW];
                for (int k = 1; k < D; k++) dly[k] <= dly[k-1];
            end
            assign aligned[CW*ii +: CW] = dly[D-1];
        end
    end

    function automatic logic [WID_OUT-1:0] requant(input logic [WID_PSUM-1:0] x,
                                                   input logic [WID_SHIFT-1:0] sh);
        logic signed [WID_PSUM:0] rnd;
        logic signed [WID_PSUM:0] r;
        logic signed [WID_PSUM:0] y;
        rnd = '0;
        if (sh != '0) rnd = {{WID_PSUM{1'b0}}, 1'b1} << (sh - 1'b1);
        r = $signed({x[WID_PSUM-1], x}) + rnd;
        y = r >>> sh;
`ifdef PSUM_DRAIN_SAT_EN
        if (y > SAT_HI) return SAT_HI[WID_OUT-1:0];
        if (y < SAT_LO) return SAT_LO[WID_OUT-1:0];
`endif
        return y[WID_OUT-1:0];
    endfunction

    always_comb begin
        q_data_d = '0;
        for (int l = 0; l < LANES; l++)
            q_data_d[WID_OUT*l +: WID_OUT] = requant(aligned[WID_PSUM*l +: WID_PSUM], cfg_shift);
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            q_vld  <= 1'b0;
            q_data <= '0;
        end else begin
            q_vld <= vld_sr[N_COLUMN-2];
            if (vld_sr[N_COLUMN-2]) q_data <= q_data_d;
        end
    end

    assign push  = q_vld;
    assign full  = (occ == OCW'(FIFO_DEPTH));
    assign pop   = out_vld && out_rdy;
    assign wr_en = push && !full;

    always_ff @(posedge clk_l) begin
        if (wr_en) mem[wr_ptr] <= q_data;
    end

    // A push into a full FIFO is dropped; only the sticky flag records it.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (push && full) ovf_q <= 1'b1;
        end
    end

    assign out_vld  = (occ != '0);
    assign out_data = out_vld ? mem[rd_ptr] : '0;

    // Credits: every beat already in the pipeline will need a FIFO slot.
    always_comb begin
        inflight = SW'(q_vld);
        for (int i = 0; i < N_COLUMN - 1; i++) inflight = inflight + SW'(vld_sr[i]);
    end

    assign used     = SW'(occ) + inflight;
    assign psum_rdy = (used < SW'(FIFO_DEPTH));

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A drain finishing on the same cycle a new psum_vld arrives starts the next drain at once.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == RUN && push) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == len_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
        if (state_d == IDLE && psum_vld) begin
            state_d = RUN;
            len_d   = (cfg_len == '0) ? WID_LEN'(1) : cfg_len;
            cnt_d   = '0;
        end
    end

    always_comb begin
        drain_done = done_q;
        ovf_err    = ovf_q;
    end

endmodule

// File: tb/tb_sblk_psum_drain.sv
// Directed bench for sblk_psum_drain: latency, requant, deskew, backpressure, overflow, drain_done and reset.
module tb_sblk_psum_drain;

    logic         clk_l = 1'b0;
    logic         rst_n;
    logic [255:0] psum_rd_data;
    logic         psum_vld;
    logic         psum_rdy;
    logic [4:0]   cfg_shift;
    logic [9:0]   cfg_len;
    logic [63:0]  out_data;
    logic         out_vld;
    logic         out_rdy;
    logic         drain_done;
    logic         ovf_err;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [63:0]  exp_q[$];
    logic         hist_v [4];
    logic [63:0]  hist_d [4];

    always #5 clk_l = ~clk_l;

    sblk_psum_drain dut (
        .clk_l        (clk_l),
        .rst_n        (rst_n),
        .psum_rd_data (psum_rd_data),
        .psum_vld     (psum_vld),
        .psum_rdy     (psum_rdy),
        .cfg_shift    (cfg_shift),
        .cfg_len      (cfg_len),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .drain_done   (drain_done),
        .ovf_err      (ovf_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_l);
        #1;
    endtask

    // One cycle of skewed stimulus: column ii carries the beat issued ii cycles ago.
    task automatic drive_cycle(input logic v, input logic [31:0] lo, input logic [31:0] hi);
        for (int i = 3; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_d[i] = hist_d[i-1];
        end
        hist_v[0] = v;
        hist_d[0] = {hi, lo};
        for (int ii = 0; ii < 4; ii++)
            psum_rd_data[64*ii +: 64] = hist_v[ii] ? hist_d[ii] : 64'hDEADBEEF_DEADBEEF;
        psum_vld = v;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_out_vld"}, 64'(out_vld), 64'd0);
        check_eq({pfx, "_out_data"}, out_data, 64'd0);
        check_eq({pfx, "_drain_done"}, 64'(drain_done), 64'd0);
        check_eq({pfx, "_ovf_err"}, 64'(ovf_err), 64'd0);
        check_eq({pfx, "_psum_rdy"}, 64'(psum_rdy), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) hist_v[i] = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;
        int pulse_at;
        int seen;
        logic [31:0] cv;
        logic [63:0] exp;

        rst_n        = 1'b0;
        psum_vld     = 1'b0;
        psum_rd_data = '0;
        cfg_shift    = '0;
        cfg_len      = 10'd1;
        out_rdy      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Nominal: 0x123 + 8 >> 4 = 0x12, first out_vld at t+5, len 1 -> done at t+5.
        cfg_shift = 5'd4;
        cfg_len   = 10'd1;
        drive_cycle(1'b1, 32'h123, 32'h123);
        idle(3);
        check_eq("nom_vld_early", 64'(out_vld), 64'd0);
        idle(1);
        check_eq("nom_vld", 64'(out_vld), 64'd1);
        check_eq("nom_data", out_data, {8{8'h12}});
        check_eq("nom_done", 64'(drain_done), 64'd1);
        idle(1);
        check_eq("nom_vld_after", 64'(out_vld), 64'd0);
        check_eq("nom_done_after", 64'(drain_done), 64'd0);

        // Saturation vs wrap with shift 0.
        cfg_shift = 5'd0;
        drive_cycle(1'b1, 32'h0001_0000, 32'hFFFF_0000);
        idle(4);
        check_eq("sat_vld", 64'(out_vld), 64'd1);
`ifdef PSUM_DRAIN_SAT_EN
        check_eq("sat_data", out_data, 64'h807F_807F_807F_807F);
`else
        check_eq("sat_data", out_data, 64'h0000_0000_0000_0000);
`endif
        idle(2);

        // Skew: column ii valid only at t+ii, garbage elsewhere.
        for (int c = 0; c < 4; c++) begin
            psum_rd_data = {8{32'hDEADBEEF}};
            cv = 32'(c + 1);
            psum_rd_data[64*c +: 64] = {cv, cv};
            psum_vld = (c == 0);
            tick();
        end
        idle(1);
        check_eq("skew_vld", 64'(out_vld), 64'd1);
        check_eq("skew_data", out_data, 64'h0404_0303_0202_0101);
        idle(2);

        // Backpressure: out_rdy low, issue whenever psum_rdy allows.
        out_rdy = 1'b0;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (psum_rdy) begin
                acc++;
                exp_q.push_back({8{8'(acc)}});
                drive_cycle(1'b1, 32'(acc), 32'(acc));
            end else begin
                drive_cycle(1'b0, 32'h0, 32'h0);
            end
        end
        check_eq("bp_accepted", 64'(acc), 64'd8);
        check_eq("bp_rdy_low", 64'(psum_rdy), 64'd0);
        check_eq("bp_no_ovf", 64'(ovf_err), 64'd0);
        check_eq("bp_out_vld", 64'(out_vld), 64'd1);
        check_eq("bp_hold_data", out_data, {8{8'h01}});

        // Forced ninth beat into a full FIFO.
        drive_cycle(1'b1, 32'h55, 32'h55);
        idle(5);
        check_eq("ovf_set", 64'(ovf_err), 64'd1);

        out_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_eq("bp_pop_vld", 64'(out_vld), 64'd1);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            check_eq("bp_pop_data", out_data, exp);
            idle(1);
        end
        check_eq("bp_empty", 64'(out_vld), 64'd0);
        check_eq("ovf_sticky", 64'(ovf_err), 64'd1);

        // Drain of 3 beats: single done pulse at t_last+5 = t+7.
        do_reset();
        check_eq("ovf_cleared", 64'(ovf_err), 64'd0);
        cfg_len = 10'd3;
        drive_cycle(1'b1, 32'd1, 32'd1);
        drive_cycle(1'b1, 32'd2, 32'd2);
        drive_cycle(1'b1, 32'd3, 32'd3);
        pulses   = 0;
        pulse_at = -1;
        for (int i = 3; i <= 12; i++) begin
            if (drain_done) begin
                pulses++;
                pulse_at = i;
            end
            idle(1);
        end
        check_eq("len3_pulses", 64'(pulses), 64'd1);
        check_eq("len3_pulse_at", 64'(pulse_at), 64'd7);

        // cfg_len = 0 behaves as a one-beat drain.
        cfg_len = 10'd0;
        drive_cycle(1'b1, 32'd9, 32'd9);
        idle(3);
        check_eq("len0_done_early", 64'(drain_done), 64'd0);
        idle(1);
        check_eq("len0_done", 64'(drain_done), 64'd1);
        idle(1);
        check_eq("len0_done_off", 64'(drain_done), 64'd0);
        idle(2);

        // Reset two cycles after psum_vld discards the beat.
        cfg_len   = 10'd1;
        cfg_shift = 5'd4;
        drive_cycle(1'b1, 32'h123, 32'h123);
        idle(1);
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_vld) seen++;
            idle(1);
        end
        check_eq("mid_rst_no_out", 64'(seen), 64'd0);

        drive_cycle(1'b1, 32'h123, 32'h123);
        idle(4);
        check_eq("fresh_vld", 64'(out_vld), 64'd1);
        check_eq("fresh_data", out_data, {8{8'h12}});
        check_eq("fresh_done", 64'(drain_done), 64'd1);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
